// File: rtl/key_pkg.sv
// ============================================================================
// Module   : key_pkg
// Brief    : Shared state type and default parameters for the keypad scanner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } key_state_t;

  localparam int c_def_rows       = 4;
  localparam int c_def_cols       = 4;
  localparam int c_def_scan_cyc   = 16;
  localparam int c_def_deb_cnt    = 4;
  localparam int c_def_repeat_cyc = 1024;

endpackage

`default_nettype wire

// File: rtl/key_sync.sv
// ============================================================================
// Module   : key_sync
// Brief    : Parametrised-width two-flop synchronizer, async reset to ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Ones at reset read as "no key" on the active-low columns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/key_scanner.sv
// ============================================================================
// Module   : key_scanner
// Brief    : Row-scanning matrix keypad decoder with debounce; define
//            KEY_SCANNER_REPEAT_EN to enable auto-repeat of valid_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_scanner
  import key_pkg::*;
#(
  parameter int  ROWS       = c_def_rows,
  parameter int  COLS       = c_def_cols,
  parameter int  SCAN_CYC   = c_def_scan_cyc,
  parameter int  DEB_CNT    = c_def_deb_cnt,
  parameter int  REPEAT_CYC = c_def_repeat_cyc,
  localparam int c_code_w   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [COLS-1:0]     col_i,
  output logic [ROWS-1:0]     row_o,
  output logic                det_o,
  output logic [c_code_w-1:0] code_o,
  output logic                valid_o,
  output logic                release_o
);

  localparam int c_row_w = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_col_w = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int c_slot_w = $clog2(SCAN_CYC);
  localparam int c_deb_w = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(SCAN_CYC - 1);
  localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_CNT - 1);
  localparam logic [c_row_w-1:0] c_row_last = c_row_w'(ROWS - 1);

  logic [COLS-1:0]     w_col_s;
  logic [c_col_w-1:0]  w_low_idx;
  logic                w_any_low;
  logic                w_key_low;
  logic [c_row_w-1:0]  w_row_next;
  logic [c_code_w-1:0] w_code;

  key_state_t          r_state;
  logic [c_row_w-1:0]  r_row;
  logic [c_col_w-1:0]  r_col;
  logic [c_slot_w-1:0] r_slot;
  logic [c_deb_w-1:0]  r_deb;

`ifdef KEY_SCANNER_REPEAT_EN
  localparam int c_rep_w = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  logic [c_rep_w-1:0] r_rep;
`else
  // Repeat period only matters when auto-repeat is built in.
  logic w_unused_repeat;
  assign w_unused_repeat = |REPEAT_CYC;
`endif

  key_sync #(
    .WIDTH (COLS)
  ) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_i),
    .q   (w_col_s)
  );

  function automatic logic [ROWS-1:0] row_drive(input logic [c_row_w-1:0] idx);
    row_drive = ~(ROWS'(1) << idx);
  endfunction

  // Lowest active-low column wins when several keys share the row.
  always_comb begin
    w_low_idx = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!w_col_s[i]) w_low_idx = c_col_w'(i);
    end
  end

  assign w_any_low  = ~&w_col_s;
  assign w_key_low  = ~w_col_s[r_col];
  assign w_row_next = (r_row == c_row_last) ? '0 : r_row + 1'b1;
  assign w_code     = c_code_w'(int'(r_row) * COLS + int'(r_col));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SCAN;
      r_row     <= '0;
      r_col     <= '0;
      r_slot    <= '0;
      r_deb     <= '0;
      row_o     <= row_drive('0);
      det_o     <= 1'b0;
      code_o    <= '0;
      valid_o   <= 1'b0;
      release_o <= 1'b0;
`ifdef KEY_SCANNER_REPEAT_EN
      r_rep     <= '0;
`endif
    end else begin
      valid_o   <= 1'b0;
      release_o <= 1'b0;
      case (r_state)
        SCAN: begin
          if (r_slot == c_slot_last) begin
            r_slot <= '0;
            if (w_any_low) begin
              r_col   <= w_low_idx;
              r_deb   <= '0;
              r_state <= DEBOUNCE;
            end else begin
              r_row <= w_row_next;
              row_o <= row_drive(w_row_next);
            end
          end else begin
            r_slot <= r_slot + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (w_key_low) begin
            if (r_deb == c_deb_last) begin
              r_deb   <= '0;
              r_state <= PRESSED;
              det_o   <= 1'b1;
              valid_o <= 1'b1;
              code_o  <= w_code;
`ifdef KEY_SCANNER_REPEAT_EN
              r_rep   <= '0;
`endif
            end else begin
              r_deb <= r_deb + 1'b1;
            end
          end else begin
            r_deb   <= '0;
            r_slot  <= '0;
            r_row   <= w_row_next;
            row_o   <= row_drive(w_row_next);
            r_state <= SCAN;
          end
        end

        PRESSED: begin
          if (!w_key_low) begin
            // The first high cycle already counts toward the release debounce.
            if (DEB_CNT == 1) begin
              release_o <= 1'b1;
              det_o     <= 1'b0;
              r_deb     <= '0;
              r_slot    <= '0;
              r_row     <= w_row_next;
              row_o     <= row_drive(w_row_next);
              r_state   <= SCAN;
            end else begin
              r_deb   <= c_deb_w'(1);
              r_state <= RELEASE;
            end
          end else begin
`ifdef KEY_SCANNER_REPEAT_EN
            if (r_rep == c_rep_w'(REPEAT_CYC - 1)) begin
              r_rep   <= '0;
              valid_o <= 1'b1;
            end else begin
              r_rep <= r_rep + 1'b1;
            end
`endif
          end
        end

        RELEASE: begin
          if (!w_key_low) begin
            if (r_deb == c_deb_last) begin
              release_o <= 1'b1;
              det_o     <= 1'b0;
              r_deb     <= '0;
              r_slot    <= '0;
              r_row     <= w_row_next;
              row_o     <= row_drive(w_row_next);
              r_state   <= SCAN;
            end else begin
              r_deb <= r_deb + 1'b1;
            end
          end else begin
            r_deb   <= '0;
            r_state <= PRESSED;
          end
        end

        default: r_state <= SCAN;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_key_scanner.sv
// ============================================================================
// Module   : tb_key_scanner
// Brief    : Self-checking bench for key_scanner with a keypad matrix model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_scanner;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int SCAN_CYC   = 4;
  localparam int DEB_CNT    = 3;
  localparam int REPEAT_CYC = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] col_i;
  logic [3:0] row_o;
  logic       det_o;
  logic [3:0] code_o;
  logic       valid_o;
  logic       release_o;

  typedef struct {
    bit is_rel;
    int code;
    int next_row;
  } ev_t;

  typedef struct {
    int r1;
    int c1;
    int r2;
    int c2;
    int code;
  } vec_t;

  ev_t        sb[$];
  ev_t        mon_e;
  int         vcyc[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit [3:0][3:0] keys;
  bit         bounce_en = 1'b0;
  bit         bounce_mask = 1'b0;

  always #5 clk = ~clk;

  key_scanner #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .SCAN_CYC   (SCAN_CYC),
    .DEB_CNT    (DEB_CNT),
    .REPEAT_CYC (REPEAT_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col_i     (col_i),
    .row_o     (row_o),
    .det_o     (det_o),
    .code_o    (code_o),
    .valid_o   (valid_o),
    .release_o (release_o)
  );

  // Keypad matrix: a held key pulls its column low while its row is driven.
  always_comb begin
    col_i = 4'hF;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (!row_o[r] && keys[r][c] && !(bounce_en && bounce_mask)) col_i[c] = 1'b0;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int rowpat(input int r);
    logic [3:0] p;
    p    = 4'hF;
    p[r] = 1'b0;
    return int'(p);
  endfunction

  task automatic wait_det(input logic v, input int lim, input string nm);
    int n;
    n = 0;
    while (det_o !== v && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(det_o), int'(v));
  endtask

  // Scoreboard monitor: every output pulse must match the next expected event.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o && release_o) chk("valid_release_overlap", 1, 0);
      if (valid_o || release_o) begin
        if (valid_o) vcyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("unexpected_event_code", int'(code_o), -1);
        end else begin
          mon_e = sb.pop_front();
          chk("event_kind", int'(release_o), int'(mon_e.is_rel));
          chk("event_code", int'(code_o), mon_e.code);
          if (mon_e.is_rel) chk("resume_row", int'(row_o), rowpat(mon_e.next_row));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    int   n0;
    int   seen;
    logic [3:0] prev;

    vt[0] = '{2, 1, -1, -1, 9};
    vt[1] = '{0, 0, -1, -1, 0};
    vt[2] = '{3, 3, -1, -1, 15};
    vt[3] = '{1, 3, 1, 0, 4};
    vt[4] = '{2, 2, 2, 3, 10};
    vt[5] = '{3, 0, -1, -1, 12};

    keys = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_row", int'(row_o), 14);
    chk("reset_det", int'(det_o), 0);
    chk("reset_code", int'(code_o), 0);
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_release", int'(release_o), 0);

    // Idle scan: each row low for SCAN_CYC cycles, in order.
    rst = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      chk("idle_row", int'(row_o), rowpat((n / SCAN_CYC) % ROWS));
    end
    chk("idle_det", int'(det_o), 0);

    for (int i = 0; i < 6; i++) begin
      sb.push_back('{1'b0, vt[i].code, 0});
      sb.push_back('{1'b1, vt[i].code, (vt[i].r1 + 1) % ROWS});
      keys[vt[i].r1][vt[i].c1] = 1'b1;
      if (vt[i].r2 >= 0) keys[vt[i].r2][vt[i].c2] = 1'b1;
      wait_det(1'b1, 100, "press_det");
      chk("press_code", int'(code_o), vt[i].code);
      repeat (10) @(negedge clk);
      chk("hold_code", int'(code_o), vt[i].code);
      chk("hold_det", int'(det_o), 1);
      keys = '0;
      wait_det(1'b0, 60, "release_det");
      @(negedge clk);
      chk("code_after_release", int'(code_o), vt[i].code);
      chk("sb_drained", sb.size(), 0);
      sb.delete();
      repeat (5) @(negedge clk);
    end

    // Bouncing contact on row2/col1: debounce must never complete.
    keys[2][1] = 1'b1;
    bounce_en  = 1'b1;
    seen       = 0;
    prev       = row_o;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (i % 2 == 1) bounce_mask = ~bounce_mask;
      if (prev == 4'b1011 && row_o != prev) begin
        chk("bounce_next_row", int'(row_o), 4'b0111);
        seen++;
      end
      prev = row_o;
    end
    chk("bounce_row_seen", int'(seen > 0), 1);
    chk("bounce_det", int'(det_o), 0);
    keys      = '0;
    bounce_en = 1'b0;
    repeat (5) @(negedge clk);

    // Long hold: auto-repeat only when built in.
    sb.push_back('{1'b0, 6, 0});
`ifdef KEY_SCANNER_REPEAT_EN
    sb.push_back('{1'b0, 6, 0});
    sb.push_back('{1'b0, 6, 0});
`endif
    sb.push_back('{1'b1, 6, 2});
    n0 = vcyc.size();
    keys[1][2] = 1'b1;
    wait_det(1'b1, 100, "rep_det");
    repeat (40) @(negedge clk);
    keys = '0;
    wait_det(1'b0, 60, "rep_release_det");
    @(negedge clk);
    chk("rep_sb_drained", sb.size(), 0);
    sb.delete();
`ifdef KEY_SCANNER_REPEAT_EN
    chk("rep_valid_count", vcyc.size() - n0, 3);
    if (vcyc.size() - n0 == 3) begin
      chk("rep_gap1", vcyc[n0 + 1] - vcyc[n0], REPEAT_CYC);
      chk("rep_gap2", vcyc[n0 + 2] - vcyc[n0 + 1], REPEAT_CYC);
    end
`else
    chk("rep_valid_count", vcyc.size() - n0, 1);
`endif
    repeat (5) @(negedge clk);

    // Asynchronous reset while a key is held.
    sb.push_back('{1'b0, 3, 0});
    keys[0][3] = 1'b1;
    wait_det(1'b1, 100, "rst_press_det");
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_pressed_det", int'(det_o), 0);
    chk("rst_pressed_row", int'(row_o), 14);
    chk("rst_pressed_release", int'(release_o), 0);
    chk("rst_pressed_code", int'(code_o), 0);
    keys = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_det", int'(det_o), 0);
    chk("post_rst_sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_scanner.md
KEY_SCANNER -- requirements
Module: key_scanner

Interface
REQ-001 The block SHALL have parameter ROWS, default 4, giving the number of keypad rows driven (range 1..8).
REQ-002 The block SHALL have parameter COLS, default 4, giving the number of keypad columns sensed (range 1..8).
REQ-003 The block SHALL have parameter SCAN_CYC, default 16, giving the clock cycles per row slot (range ≥3).
REQ-004 The block SHALL have parameter DEB_CNT, default 4, giving the consecutive stable cycles needed to accept a press or release (range ≥1).
REQ-005 The block SHALL have parameter REPEAT_CYC, default 1024, giving the auto-repeat period in cycles; it is used only under REQ-023.
REQ-006 The block SHALL have port clk, input, width 1: the single clock, rising edge.
REQ-007 The block SHALL have port rst, input, width 1: reset, asynchronous and active-high.
REQ-008 The block SHALL have port col_i, input, width COLS: keypad columns, active-low, asynchronous to clk.
REQ-009 The block SHALL have port row_o, output, width ROWS: row drive, active-low, at most one bit low.
REQ-010 The block SHALL have port det_o, output, width 1: high while an accepted key is held.
REQ-011 The block SHALL have port code_o, output, width max(1,$clog2(ROWS*COLS)): key code equal to row*COLS+col.
REQ-012 The block SHALL have port valid_o, output, width 1: one-cycle pulse that qualifies a new code_o.
REQ-013 The block SHALL have port release_o, output, width 1: one-cycle pulse when the accepted key is released.

Function
REQ-014 The block SHALL pass col_i through a 2-flop synchronizer; all logic SHALL use only the synchronized value colS, so input-to-decision latency is 2 cycles.
REQ-015 The FSM SHALL have states SCAN, DEBOUNCE, PRESSED and RELEASE; all outputs SHALL be registered.
REQ-016 In SCAN the block SHALL drive row r low for SCAN_CYC cycles and sample colS on the last cycle of the slot. If no bit is low, r SHALL advance, wrapping from ROWS-1 to 0. If any bit is low, the block SHALL capture c = the lowest low column index, stay on row r, and enter DEBOUNCE.
REQ-017 In DEBOUNCE the block SHALL count consecutive cycles with colS[c]==0. When the count reaches DEB_CNT, the block SHALL enter PRESSED, set code_o=r*COLS+c, and pulse valid_o in the same cycle that det_o rises. If colS[c]==1 before the count completes, the block SHALL return to SCAN at row r+1 (with wrap) with no pulse.
REQ-018 In PRESSED the block SHALL hold det_o=1 and hold row r. The first cycle with colS[c]==1 SHALL move the block to RELEASE.
REQ-019 In RELEASE the block SHALL count consecutive cycles with colS[c]==1. When the count reaches DEB_CNT, the block SHALL pulse release_o, clear det_o the same cycle, and return to SCAN at row r+1. If colS[c]==0 before that, the block SHALL return to PRESSED without a valid_o pulse.
REQ-020 Simultaneous keys: only one key SHALL be tracked. Within a row the lowest column wins; across rows the first row scanned wins. Other keys SHALL be ignored until release.
REQ-021 code_o SHALL hold its last value outside valid_o cycles; valid_o and release_o SHALL never be high in the same cycle.

Reset
REQ-022 On rst=1, immediately and regardless of state, the block SHALL enter SCAN at row 0 with: row_o = all ones except bit0=0, det_o=0, code_o=0, valid_o=0, release_o=0, all counters 0, synchronizer flops set to all ones. Scanning SHALL resume on the first clk edge after rst falls.

Configuration
REQ-023 With KEY_SCANNER_REPEAT_EN defined, while in PRESSED the block SHALL re-pulse valid_o with an unchanged code_o every REPEAT_CYC cycles after the initial pulse; the repeat counter SHALL clear on entry to PRESSED and hold during RELEASE. Without the macro, the block SHALL produce exactly one valid_o per accepted press and SHALL implement no repeat counter.

Structure
REQ-024 Package key_pkg SHALL hold the state enum typedef (key_state_t) and the default parameter constants.
REQ-025 Sub-module key_sync SHALL be the parametrised-width 2-flop synchronizer with async reset to ones, and SHALL be instantiated once for col_i.

Verification (ROWS=COLS=4, SCAN_CYC=4, DEB_CNT=3, REPEAT_CYC=16)
REQ-026 No key, col_i=1111 for 64 cycles -> row_o cycles 1110,1101,1011,0111, 4 cycles each; det_o=0; no pulses.
REQ-027 Key at row2/col1 held steady -> one valid_o with code_o=9 and det_o=1. Releasing it for at least 3 cycles -> one release_o, det_o=0, scanning resumes at row 3.
REQ-028 col1 toggles every 2 cycles during DEBOUNCE -> no valid_o; scanning resumes at the next row.
REQ-029 Keys row1/col3 and row1/col0 pressed together -> code_o=4; the second key never reported while the first is held.
REQ-030 rst pulsed while in PRESSED -> the same cycle gives det_o=0 and row_o=1110, with no release_o pulse.
REQ-031 Key held 40 cycles past the first valid_o: with KEY_SCANNER_REPEAT_EN -> 2 further valid_o pulses 16 cycles apart; without the macro -> none.
